// File: rtl/ss_tr_16b.sv
// Source-select temporary register: a 5:1 mux of datapath values feeding a
// load-enabled register whose contents drive the downstream operand paths.
module ss_tr_16b #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic             tr_write,
    input  logic [2:0]       tr_src,
    output logic [WIDTH-1:0] tr
);

    logic [WIDTH-1:0] sel;
    logic [WIDTH-1:0] tr_q;

    // Reserved selects resolve to zero so they can never load X into TR.
    always_comb begin
        sel = '0;
        case (tr_src)
            3'd0:    sel = a;
            3'd1:    sel = b;
            3'd2:    sel = c;
            3'd3:    sel = d;
            3'd4:    sel = e;
            default: sel = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tr_q <= '0;
        end else if (tr_write) begin
            tr_q <= sel;
        end
    end

    assign tr = tr_q;

endmodule

// File: tb/tb_ss_tr_16b.sv
// Self-checking bench for ss_tr_16b: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural model of the register.
module tb_ss_tr_16b;

    logic        CLK;
    logic        reset;
    logic [15:0] a, b, c, d, e;
    logic        tr_write;
    logic [2:0]  tr_src;
    logic [15:0] tr;

    int checkCount = 0;
    int passCount  = 0;
    bit testsDone  = 0;

    logic [15:0] expTr = 16'h0000;

    ss_tr_16b #(.WIDTH(16)) dut (
        .CLK      (CLK),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .e        (e),
        .tr_write (tr_write),
        .tr_src   (tr_src),
        .tr       (tr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Model: TR is the selected source (zero for reserved codes) captured on
    // a write edge, and is zero whenever reset is low.
    always @(posedge CLK or negedge reset) begin
        logic [15:0] srcs [0:4];
        srcs[0] = a; srcs[1] = b; srcs[2] = c; srcs[3] = d; srcs[4] = e;
        if (!reset)
            expTr <= 16'h0000;
        else if (tr_write)
            expTr <= (tr_src < 3'd5) ? srcs[tr_src] : 16'h0000;
    end

    // Compare against the model on every falling edge, away from the sampling edge.
    always @(negedge CLK) begin
        if (!testsDone) begin
            checkCount++;
            if (tr === expTr)
                passCount++;
            else
                $display("[TB] FAIL model_compare t=%0t: tr=%h expected=%h", $time, tr, expTr);
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] expected);
        checkCount++;
        if (tr === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: tr=%h expected=%h", name, tr, expected);
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic wr, input logic [2:0] src);
        tr_write = wr;
        tr_src   = src;
    endtask

    initial begin
        reset = 1'b0;
        a = 16'h0000; b = 16'h0001; c = 16'h0000; d = 16'h0000; e = 16'h0000;
        applyStimulus(1'b1, 3'd1);

        // Reset held low ignores edges and tr_write.
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("reset_hold", 16'h0000);
        end

        // Release, load 0x1234, then reset mid-cycle clears immediately.
        reset = 1'b1;
        a = 16'h1234;
        applyStimulus(1'b1, 3'd0);
        stepCycle();
        checkOutput("load_1234", 16'h1234);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 16'h0000);
        stepCycle();
        reset = 1'b1;
        stepCycle();
        checkOutput("post_release_load", 16'h1234);

        // Select sweep.
        a = 16'd0; b = 16'd1; c = 16'd2; d = 16'd3; e = 16'd4;
        for (int s = 0; s < 5; s++) begin
            applyStimulus(1'b1, 3'(s));
            stepCycle();
            checkOutput($sformatf("sweep_src%0d", s), 16'(s));
        end

        // Hold while tr_write is low.
        d = 16'h00AB;
        applyStimulus(1'b1, 3'd3);
        stepCycle();
        checkOutput("hold_load", 16'h00AB);
        applyStimulus(1'b0, 3'd4);
        d = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("hold", 16'h00AB);
        end
        applyStimulus(1'b1, 3'd4);
        stepCycle();
        checkOutput("hold_release", 16'h0004);

        // Latency: a change between edges waits for the next edge.
        c = 16'h0002;
        applyStimulus(1'b1, 3'd2);
        stepCycle();
        checkOutput("latency_before", 16'h0002);
        #3;
        c = 16'hBEEF;
        #1;
        checkOutput("latency_midcycle", 16'h0002);
        stepCycle();
        checkOutput("latency_after", 16'hBEEF);

        // Reserved selects load zero.
        a = 16'hFFFF; b = 16'hFFFF; c = 16'hFFFF; d = 16'hFFFF; e = 16'hFFFF;
        for (int s = 5; s < 8; s++) begin
            applyStimulus(1'b1, 3'(s));
            stepCycle();
            checkOutput($sformatf("reserved_src%0d", s), 16'h0000);
            applyStimulus(1'b1, 3'd0);
            stepCycle();
            checkOutput("reserved_reload", 16'hFFFF);
        end

        // Full-width data.
        e = 16'h8001;
        applyStimulus(1'b1, 3'd4);
        stepCycle();
        checkOutput("width_8001", 16'h8001);
        a = 16'h7FFE;
        applyStimulus(1'b1, 3'd0);
        stepCycle();
        checkOutput("width_7ffe", 16'h7FFE);

        stepCycle();
        testsDone = 1'b1;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/ss_tr_16b.md
Name: ss_tr_16b

Overview:
- Source-select temporary register (TR) for the 16-bit processor datapath.
- A 5:1 multiplexer picks one of five 16-bit datapath values using tr_src.
- The selected value is captured into a 16-bit register on the rising clock edge when tr_write is asserted.
- The registered value drives tr, which feeds downstream datapath stages (ALU/memory operand paths).

Parameters:
- WIDTH, 16, data width of every source input and of the TR register/output.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 clears TR immediately.
- a  input  WIDTH  source 0.
- b  input  WIDTH  source 1.
- c  input  WIDTH  source 2.
- d  input  WIDTH  source 3.
- e  input  WIDTH  source 4.
- tr_write  input  1  load enable for TR; active-high.
- tr_src  input  3  source select: 0=a, 1=b, 2=c, 3=d, 4=e.
- tr  output  WIDTH  current TR contents (registered output).

Behaviour:
- Clocking and reset:
  - One clock domain (CLK). Reset is asynchronous and active-low, on port reset.
  - reset=0 forces TR to 0x0000 immediately, without waiting for a clock edge.
  - TR stays 0x0000 for as long as reset is low. Clock edges and tr_write are ignored while reset is low.
  - Reset release (0->1) takes effect at the next rising edge; no load occurs on the release itself.
- Mux (combinational):
  - sel = a/b/c/d/e for tr_src = 0/1/2/3/4.
  - tr_src = 5, 6, 7 (reserved) selects 0x0000.
- Register:
  - On a rising CLK edge with reset=1 and tr_write=1: TR <= sel.
  - With tr_write=0: TR holds its value.
- Output: tr = TR. No combinational path from the a..e, tr_src or tr_write inputs to tr.
- Latency:
  - A source or select change becomes visible on tr after the next qualifying rising edge (1 cycle).
  - With tr_write held at 1, tr tracks the selected source delayed by one cycle.
- Timing boundaries:
  - Source or select changes between edges have no effect until the next edge. Inputs are sampled only at the edge.
  - If reset asserts in the same timestep as an edge with tr_write=1, reset wins and TR = 0x0000.
- Data handling: the full WIDTH bits are passed unchanged. No sign extension, truncation or arithmetic.
- X-handling: the reserved tr_src values must never propagate X to TR; they load zero as specified above.

Test Plan:
1. Reset: drive reset=0 with tr_write=1, tr_src=1, b=0x0001 for several cycles -> tr=0x0000 throughout. Assert reset=0 mid-cycle after TR=0x1234 -> tr=0x0000 immediately, before the next edge.
2. Select sweep: reset=1, tr_write=1, a..e = 0,1,2,3,4. Step tr_src 0..4, one per 10 ns clock period, checking one period after each change -> tr = 0,1,2,3,4 respectively.
3. Hold: load tr_src=3 with d=0x00AB, so tr=0x00AB. Set tr_write=0, change tr_src to 4 and d to 0xFFFF, run 3 cycles -> tr stays 0x00AB. Set tr_write=1 -> tr=e after the next edge.
4. Latency: tr_write=1, tr_src=2; change c from 0x0002 to 0xBEEF midway between edges -> tr stays 0x0002 until the next rising edge, then becomes 0xBEEF.
5. Reserved selects: tr_src = 5, 6, 7 with a..e all 0xFFFF and tr_write=1 -> tr=0x0000 after each edge, with no X on tr.
6. Full-width data: e=0x8001, tr_src=4 -> tr=0x8001 with all bits intact. Then a=0x7FFE, tr_src=0 -> tr=0x7FFE.
